// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter that time-shares the seven-segment display byte between
// NUM_SRC requesters, with a fixed dwell per owner and a rotation lock.
module hex_display_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [8*NUM_SRC-1:0]       data,
  input  logic                       lock,
  output logic [7:0]                 hex_out,
  output logic [NUM_SRC-1:0]         grant,
  output logic [$clog2(NUM_SRC)-1:0] src_idx,
  output logic                       active,
  output logic                       switch_pulse
);

  localparam int unsigned IW = $clog2(NUM_SRC);
  localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t              state, state_d;
  logic [IW-1:0]       cur, cur_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [7:0]          hex_d;
  logic [NUM_SRC-1:0]  grant_d;
  logic [IW-1:0]       idx_d;
  logic                active_d;
  logic                pulse_d;

  logic [7:0]          src_byte [NUM_SRC];
  logic [IW-1:0]       pick;
  logic                found;
  logic [NUM_SRC-1:0]  pick_oh;
  int unsigned         k;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_byte[i] = data[8*i +: 8];
    end
  end

  // Scan starts one past the owner so the owner itself is considered last.
  always_comb begin
    pick  = cur;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      k = (32'(cur) + 1 + i) % NUM_SRC;
      if (!found && req[k]) begin
        pick  = IW'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_comb begin
    state_d  = state;
    cur_d    = cur;
    cnt_d    = cnt;
    hex_d    = hex_out;
    grant_d  = grant;
    idx_d    = src_idx;
    active_d = active;
    pulse_d  = 1'b0;

    unique case (state)
      IDLE: begin
        grant_d  = '0;
        active_d = 1'b0;
        if (|req) begin
          state_d  = SHOW;
          cur_d    = pick;
          cnt_d    = RELOAD;
          hex_d    = src_byte[pick];
          grant_d  = pick_oh;
          idx_d    = pick;
          active_d = 1'b1;
          pulse_d  = 1'b1;
        end
      end
      SHOW: begin
        if (!req[cur]) begin
          if (|req) begin
            cur_d   = pick;
            cnt_d   = RELOAD;
            hex_d   = src_byte[pick];
            grant_d = pick_oh;
            idx_d   = pick;
            pulse_d = 1'b1;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            active_d = 1'b0;
          end
        end else if (lock) begin
          hex_d = src_byte[cur];
        end else if (cnt == '0) begin
          cur_d   = pick;
          cnt_d   = RELOAD;
          hex_d   = src_byte[pick];
          grant_d = pick_oh;
          idx_d   = pick;
          pulse_d = (pick != cur);
        end else begin
          cnt_d = cnt - 1'b1;
          hex_d = src_byte[cur];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur          <= IW'(NUM_SRC - 1);
      cnt          <= '0;
      hex_out      <= '0;
      grant        <= '0;
      src_idx      <= '0;
      active       <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_d;
      cur          <= cur_d;
      cnt          <= cnt_d;
      hex_out      <= hex_d;
      grant        <= grant_d;
      src_idx      <= idx_d;
      active       <= active_d;
      switch_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter (NUM_SRC=4, DWELL_CYCLES=4): a cycle model feeds
// a scoreboard queue, and each scenario task adds targeted checks of its own.
module tb_hex_display_arbiter;

  localparam int unsigned NS    = 4;
  localparam int unsigned DWELL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic        lock;
  logic [7:0]  hex_out;
  logic [3:0]  grant;
  logic [1:0]  src_idx;
  logic        active;
  logic        switch_pulse;

  hex_display_arbiter #(.NUM_SRC(NS), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .lock(lock),
    .hex_out(hex_out), .grant(grant), .src_idx(src_idx),
    .active(active), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: m_served counts cycles the owner has been on screen.
  logic        m_show;
  int unsigned m_cur;
  int unsigned m_served;
  logic [3:0]  e_grant;
  logic [7:0]  e_hex;
  logic [1:0]  e_idx;
  logic        e_active;
  logic        e_pulse;
  logic [15:0] sb [$];

  function automatic int unsigned next_owner(input logic [3:0] q, input int unsigned c);
    for (int unsigned off = 1; off <= NS; off++) begin
      if (q[(c + off) % NS]) return (c + off) % NS;
    end
    return c;
  endfunction

  task automatic take(input int unsigned n, input logic [31:0] d, input logic pulse);
    m_cur    = n;
    m_served = 1;
    m_show   = 1'b1;
    e_grant  = 4'b0001 << n;
    e_hex    = d[8*n +: 8];
    e_idx    = 2'(n);
    e_active = 1'b1;
    e_pulse  = pulse;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, wait past the edge.
  task automatic step(input logic r, input logic [3:0] q, input logic l, input logic [31:0] d);
    @(negedge clk);
    rst_n = r; req = q; lock = l; data = d;
    if (!r) begin
      m_show = 1'b0; m_cur = NS - 1; m_served = 0;
      e_grant = '0; e_hex = '0; e_idx = '0; e_active = 1'b0; e_pulse = 1'b0;
    end else begin
      e_pulse = 1'b0;
      if (!m_show) begin
        if (q != 0) take(next_owner(q, m_cur), d, 1'b1);
      end else if (!q[m_cur]) begin
        if (q != 0) take(next_owner(q, m_cur), d, 1'b1);
        else begin m_show = 1'b0; e_grant = '0; e_active = 1'b0; end
      end else if (l) begin
        e_hex = d[8*m_cur +: 8];
      end else if (m_served == DWELL) begin
        take(next_owner(q, m_cur), d, next_owner(q, m_cur) != m_cur);
      end else begin
        m_served++;
        e_hex = d[8*m_cur +: 8];
      end
    end
    sb.push_back({e_grant, e_hex, e_idx, e_active, e_pulse});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    logic [15:0] exp_v;
    #1;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      n_checks++;
      if ({grant, hex_out, src_idx, active, switch_pulse} !== exp_v) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got grant=%b hex=%h idx=%0d act=%b pulse=%b expected grant=%b hex=%h idx=%0d act=%b pulse=%b",
                 $time, grant, hex_out, src_idx, active, switch_pulse,
                 exp_v[15:12], exp_v[11:4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic test_reset();
    step(1'b0, 4'hF, 1'b0, 32'h44332211);
    step(1'b0, 4'hF, 1'b0, 32'h44332211);
    n_checks++;
    if ({grant, hex_out, active} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_values got grant=%b hex=%h act=%b expected 0000/00/0", grant, hex_out, active);
    end
    step(1'b1, 4'hF, 1'b0, 32'h44332211);
    n_checks++;
    if (grant !== 4'b0001 || switch_pulse !== 1'b1 || hex_out !== 8'h11) begin
      n_fail++;
      $display("FAIL first_grant got grant=%b pulse=%b hex=%h expected 0001/1/11", grant, switch_pulse, hex_out);
    end
    step(1'b1, 4'hF, 1'b0, 32'h44332211);
    n_checks++;
    if (switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width got %b expected 0", switch_pulse);
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    step(1'b0, 4'h0, 1'b0, 32'h0);
    for (int c = 0; c < 22; c++) begin
      step(1'b1, 4'b0001, 1'b0, 32'h000000A5);
      pulses += int'(switch_pulse);
    end
    n_checks++;
    if (pulses != 1 || grant !== 4'b0001 || hex_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_hold got pulses=%0d grant=%b hex=%h expected 1/0001/a5", pulses, grant, hex_out);
    end
    step(1'b1, 4'b0001, 1'b0, 32'h0000003C);
    n_checks++;
    if (hex_out !== 8'h3C || switch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL live_track got hex=%h pulse=%b expected 3c/0", hex_out, switch_pulse);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    step(1'b0, 4'h0, 1'b0, 32'h0);
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 4'b1011, 1'b0, 32'h43322110);
      n_checks++;
      if (src_idx !== seq[c/4] || switch_pulse !== (c % 4 == 0)) begin
        n_fail++;
        $display("FAIL rotation c=%0d got idx=%0d pulse=%b expected idx=%0d pulse=%b",
                 c, src_idx, switch_pulse, seq[c/4], (c % 4 == 0));
      end
    end
  endtask

  task automatic test_drop();
    step(1'b0, 4'h0, 1'b0, 32'h0);
    for (int c = 0; c < 6; c++) step(1'b1, 4'b1011, 1'b0, 32'hD4C3B2A1);
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL drop_pre got grant=%b expected 0010", grant);
    end
    for (int c = 6; c < 11; c++) begin
      step(1'b1, 4'b1001, 1'b0, 32'hD4C3B2A1);
      n_checks++;
      if (grant !== ((c < 10) ? 4'b1000 : 4'b0001)) begin
        n_fail++;
        $display("FAIL drop_dwell c=%0d got grant=%b expected %b", c, grant, (c < 10) ? 4'b1000 : 4'b0001);
      end
    end
  endtask

  task automatic test_lock();
    step(1'b0, 4'h0, 1'b0, 32'h0);
    step(1'b1, 4'hF, 1'b0, 32'h04030201);
    step(1'b1, 4'hF, 1'b0, 32'h04030201);
    for (int c = 2; c < 22; c++) step(1'b1, 4'hF, 1'b1, 32'h04030201);
    n_checks++;
    if (grant !== 4'b0001 || hex_out !== 8'h01) begin
      n_fail++;
      $display("FAIL lock_hold got grant=%b hex=%h expected 0001/01", grant, hex_out);
    end
    step(1'b1, 4'hF, 1'b0, 32'h04030201);
    step(1'b1, 4'hF, 1'b0, 32'h04030201);
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_remaining got grant=%b expected 0001", grant);
    end
    step(1'b1, 4'hF, 1'b0, 32'h04030201);
    n_checks++;
    if (grant !== 4'b0010 || switch_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_release got grant=%b pulse=%b expected 0010/1", grant, switch_pulse);
    end
    step(1'b1, 4'b1101, 1'b1, 32'h04030201);
    n_checks++;
    if (grant !== 4'b0100 || hex_out !== 8'h03) begin
      n_fail++;
      $display("FAIL lock_drop got grant=%b hex=%h expected 0100/03", grant, hex_out);
    end
    step(1'b1, 4'h0, 1'b0, 32'h04030201);
    n_checks++;
    if (grant !== 4'b0000 || active !== 1'b0 || hex_out !== 8'h03) begin
      n_fail++;
      $display("FAIL to_idle got grant=%b act=%b hex=%h expected 0000/0/03", grant, active, hex_out);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 4'h0, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) step(1'b1, 4'hF, 1'b0, 32'h88776655);
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_owner got grant=%b expected 0100", grant);
    end
    step(1'b0, 4'hF, 1'b0, 32'h88776655);
    n_checks++;
    if ({grant, hex_out, src_idx, active, switch_pulse} !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset got grant=%b hex=%h idx=%0d act=%b pulse=%b expected all zero",
               grant, hex_out, src_idx, active, switch_pulse);
    end
    step(1'b1, 4'hF, 1'b0, 32'h88776655);
    n_checks++;
    if (grant !== 4'b0001 || hex_out !== 8'h55) begin
      n_fail++;
      $display("FAIL mid_regrant got grant=%b hex=%h expected 0001/55", grant, hex_out);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req = '0; lock = 1'b0; data = '0;
    test_reset();
    test_single();
    test_rotation();
    test_drop();
    test_lock();
    test_reset_mid();
    @(posedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
